// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encoding,
// requester IDs and the latched transfer record.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic ID_IF = 1'b0;
  localparam logic ID_LS = 1'b1;

  localparam int MEM_LAT_DEFAULT = 2;

  typedef struct packed {
    logic        id;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } xfer_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the requester
// that did not win last time.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win
);

  assign win = (&req) ? ~last : req[1];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (id 0) and load/store
// (id 1). One transaction in flight; every output comes straight from a flop.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [15:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [15:0] ls_addr,
  input  logic [15:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [15:0] ls_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  localparam logic [2:0] LAT3 = 3'(MEM_LAT);

  state_t      state, state_nxt;
  xfer_t       cur, cur_nxt;
  logic        last, last_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        win, capture;
  logic [1:0]  gnt_nxt, rvalid_nxt;
  logic        mem_en_nxt, mem_we_nxt;
  logic [15:0] mem_addr_nxt, mem_wdata_nxt;

  rr_arb2 u_rr (
    .req  ({ls_req, if_req}),
    .last (last),
    .win  (win)
  );

  // Outputs are computed one cycle early so the ISSUE/RESP strobes land
  // registered in the cycle the FSM occupies that state.
  always_comb begin
    state_nxt     = state;
    cur_nxt       = cur;
    last_nxt      = last;
    cnt_nxt       = cnt;
    gnt_nxt       = 2'b00;
    rvalid_nxt    = 2'b00;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = '0;
    mem_wdata_nxt = '0;
    capture       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (if_req || ls_req) begin
          state_nxt         = ST_ISSUE;
          cur_nxt.id        = win;
          cur_nxt.we        = win & ls_we;
          cur_nxt.addr      = win ? ls_addr : if_addr;
          cur_nxt.wdata     = win ? ls_wdata : 16'h0000;
          last_nxt          = win;
          gnt_nxt[win]      = 1'b1;
          mem_en_nxt        = 1'b1;
          mem_we_nxt        = cur_nxt.we;
          mem_addr_nxt      = cur_nxt.addr;
          mem_wdata_nxt     = cur_nxt.wdata;
        end
      end
      ST_ISSUE: begin
        if (cur.we) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
          cnt_nxt   = 3'd1;
        end
      end
      ST_WAIT: begin
        // cnt == LAT3 marks the cycle mem_rdata is valid
        if (cnt == LAT3) begin
          state_nxt          = ST_RESP;
          rvalid_nxt[cur.id] = 1'b1;
          capture            = 1'b1;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur       <= '0;
      last      <= ID_IF;
      cnt       <= '0;
      busy      <= 1'b0;
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      cur       <= cur_nxt;
      last      <= last_nxt;
      cnt       <= cnt_nxt;
      busy      <= (state_nxt != ST_IDLE);
      if_gnt    <= gnt_nxt[ID_IF];
      ls_gnt    <= gnt_nxt[ID_LS];
      if_rvalid <= rvalid_nxt[ID_IF];
      ls_rvalid <= rvalid_nxt[ID_LS];
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if (capture && cur.id == ID_IF) if_rdata <= mem_rdata;
      if (capture && cur.id == ID_LS) ls_rdata <= mem_rdata;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiters (MEM_LAT 2, 1, 7) share stimulus, each with
// its own fixed-latency memory model that returns garbage off-cycle.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              if_req, ls_req, ls_we;
  logic [15:0]       if_addr, ls_addr, ls_wdata;
  logic [2:0]        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
  logic [2:0][15:0]  if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0][1:0]   fsm_state;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 7;
    logic [7:0]       vp;
    logic [7:0][15:0] dp;

    mem_arbiter #(.MEM_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt[g]), .ls_rvalid(ls_rvalid[g]), .ls_rdata(ls_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .busy(busy[g]), .fsm_state(fsm_state[g])
    );

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        vp <= '0;
        dp <= '0;
      end else begin
        vp <= {vp[6:0], mem_en[g] & ~mem_we[g]};
        dp <= {dp[6:0], memf(mem_addr[g])};
      end
    end
    assign mem_rdata[g] = vp[LAT-1] ? dp[LAT-1] : 16'hDEAD;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk({tag, "_ctl"}, {24'd0, if_gnt[g], if_rvalid[g], ls_gnt[g], ls_rvalid[g],
                          mem_en[g], mem_we[g], busy[g], 1'b0} | {30'd0, fsm_state[g]}, 32'd0);
      chk({tag, "_rdata"}, {if_rdata[g], ls_rdata[g]}, 32'd0);
      chk({tag, "_mem"}, {mem_addr[g], mem_wdata[g]}, 32'd0);
    end
  endtask

  // Cycle-by-cycle invariants on every instance
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      chk("busy_vs_state", 32'(busy[g]), 32'(fsm_state[g] != 2'd0));
      chk("gnt_mutex", 32'(if_gnt[g] & ls_gnt[g]), 32'd0);
      chk("rvalid_mutex", 32'(if_rvalid[g] & ls_rvalid[g]), 32'd0);
    end
  end

  initial begin
    int gcy[3];
    int vcy[3];
    logic [15:0] vdat[3];
    int npulse, cnt;
    logic [3:0] order;
    int ng;

    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    #1;
    chk_zero("reset");
    step(2);
    rst = 1'b0;
    step(1);

    // Fetch: gnt at cycle 1, rvalid at MEM_LAT+2
    if_req = 1'b1; if_addr = 16'h0010;
    for (int g = 0; g < 3; g++) begin gcy[g] = -1; vcy[g] = -1; vdat[g] = '0; end
    npulse = 0;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c == 1) begin
        if_req = 1'b0;
        chk("t1_mem_en", 32'(mem_en[0]), 32'd1);
        chk("t1_mem_we", 32'(mem_we[0]), 32'd0);
        chk("t1_mem_addr", 32'(mem_addr[0]), 32'h0010);
      end
      if (c == 5) chk("t1_idle_c5", 32'(fsm_state[0]), 32'd0);
      if (if_rvalid[0]) npulse++;
      for (int g = 0; g < 3; g++) begin
        if (if_gnt[g] && gcy[g] < 0) gcy[g] = c;
        if (if_rvalid[g] && vcy[g] < 0) begin vcy[g] = c; vdat[g] = if_rdata[g]; end
      end
    end
    chk("t1_gnt_cycle", 32'(gcy[0]), 32'd1);
    chk("t1_rvalid_lat2", 32'(vcy[0]), 32'd4);
    chk("t1_rvalid_lat1", 32'(vcy[1]), 32'd3);
    chk("t1_rvalid_lat7", 32'(vcy[2]), 32'd9);
    chk("t1_rdata_lat2", 32'(vdat[0]), 32'hBEEF);
    chk("t1_rdata_lat1", 32'(vdat[1]), 32'hBEEF);
    chk("t1_rdata_lat7", 32'(vdat[2]), 32'hBEEF);
    chk("t1_rvalid_pulse", 32'(npulse), 32'd1);
    chk("t1_rdata_hold", 32'(if_rdata[0]), 32'hBEEF);
    chk("t1_lat7_idle", 32'(fsm_state[2]), 32'd0);

    // Store: one ISSUE cycle, straight back to IDLE, no rvalid
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0200; ls_wdata = 16'h1234;
    step();
    ls_req = 1'b0; ls_we = 1'b0;
    chk("t2_ls_gnt", 32'(ls_gnt[0]), 32'd1);
    chk("t2_if_gnt", 32'(if_gnt[0]), 32'd0);
    chk("t2_mem_en_we", {30'd0, mem_en[0], mem_we[0]}, 32'd3);
    chk("t2_mem_addr", 32'(mem_addr[0]), 32'h0200);
    chk("t2_mem_wdata", 32'(mem_wdata[0]), 32'h1234);
    step();
    chk("t2_busy_c2", 32'(busy[0]), 32'd0);
    chk("t2_mem_en_c2", 32'(mem_en[0]), 32'd0);
    chk("t2_ls_gnt_c2", 32'(ls_gnt[0]), 32'd0);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      for (int g = 0; g < 3; g++) cnt += int'(ls_rvalid[g]);
    end
    chk("t2_no_rvalid", 32'(cnt), 32'd0);
    chk("t2_if_rdata_hold", 32'(if_rdata[0]), 32'hBEEF);

    // Tie after reset: LS, IF, LS, IF
    rst = 1'b1;
    #1;
    chk_zero("t3_reset");
    step();
    rst = 1'b0;
    step();
    ls_we = 1'b0; ls_addr = 16'h0300; if_addr = 16'h0010;
    if_req = 1'b1; ls_req = 1'b1;
    order = '0; ng = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (ng < 4) begin
        if (ls_gnt[0]) begin order[ng] = 1'b1; ng++; end
        else if (if_gnt[0]) begin order[ng] = 1'b0; ng++; end
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    chk("t3_ngrants", 32'(ng), 32'd4);
    chk("t3_order", 32'(order), 32'b0101);
    step(12);
    chk("t3_ls_rdata", 32'(ls_rdata[0]), 32'h595A);
    chk("t3_if_rdata", 32'(if_rdata[0]), 32'hBEEF);

    // Reset during WAIT of a load abandons it; next tie goes to LS
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0400;
    step();
    ls_req = 1'b0;
    chk("t4_ls_gnt", 32'(ls_gnt[0]), 32'd1);
    step();
    chk("t4_in_wait", 32'(fsm_state[0]), 32'd2);
    rst = 1'b1;
    #1;
    chk_zero("t4_reset");
    step();
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      for (int g = 0; g < 3; g++) cnt += int'(ls_rvalid[g]) + int'(ls_gnt[g]) + int'(if_gnt[g]);
    end
    chk("t4_abandoned", 32'(cnt), 32'd0);
    if_req = 1'b1; ls_req = 1'b1;
    step();
    if_req = 1'b0; ls_req = 1'b0;
    chk("t4_tie_ls", 32'(ls_gnt[0]), 32'd1);
    chk("t4_tie_not_if", 32'(if_gnt[0]), 32'd0);
    step(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, memory read latency in cycles (legal 1..7).
REQ-002 SHALL have port clk  in  1  system clock, rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port if_req  in  1  instruction-fetch read request.
REQ-005 SHALL have port if_addr  in  16  fetch address.
REQ-006 SHALL have port if_gnt  out  1  fetch grant pulse.
REQ-007 SHALL have port if_rvalid  out  1  fetch data valid pulse.
REQ-008 SHALL have port if_rdata  out  16  fetch read data.
REQ-009 SHALL have port ls_req  in  1  load/store request.
REQ-010 SHALL have port ls_we  in  1  1 = store, 0 = load.
REQ-011 SHALL have port ls_addr  in  16  load/store address.
REQ-012 SHALL have port ls_wdata  in  16  store data.
REQ-013 SHALL have port ls_gnt  out  1  load/store grant pulse.
REQ-014 SHALL have port ls_rvalid  out  1  load data valid pulse.
REQ-015 SHALL have port ls_rdata  out  16  load read data.
REQ-016 SHALL have port mem_en  out  1  memory access strobe.
REQ-017 SHALL have port mem_we  out  1  memory write enable.
REQ-018 SHALL have port mem_addr  out  16  memory address.
REQ-019 SHALL have port mem_wdata  out  16  memory write data.
REQ-020 SHALL have port mem_rdata  in  16  memory read data, valid MEM_LAT cycles after the mem_en cycle.
REQ-021 SHALL have port busy  out  1  high when the FSM is not in IDLE.
REQ-022 SHALL have port fsm_state  out  2  current FSM state encoding, for debug.

Function
REQ-023 SHALL implement FSM states IDLE=0, ISSUE=1, WAIT=2, RESP=3, all outputs registered.
REQ-024 In IDLE with any request sampled high at a clock edge, the FSM SHALL move to ISSUE and latch the winner's address, data and write flag.
REQ-025 Arbitration SHALL be round-robin: if only one request is high, grant it; if both are high, grant the requester not granted last.
REQ-026 In ISSUE, for exactly one cycle, SHALL assert the winner's gnt and mem_en, and drive mem_we, mem_addr and mem_wdata from the latched values.
REQ-027 A store SHALL go ISSUE->IDLE, with no rvalid generated.
REQ-028 A load or fetch SHALL go ISSUE->WAIT, where a 3-bit counter counts MEM_LAT cycles.
REQ-029 In the cycle mem_rdata is valid (ISSUE cycle + MEM_LAT), mem_rdata SHALL be registered and the FSM SHALL move to RESP.
REQ-030 RESP SHALL last one cycle: assert the winner's rvalid, present the registered data on its rdata, then return to IDLE.
REQ-031 For MEM_LAT=2, a read request sampled at cycle 0 SHALL give gnt in cycle 1, rvalid in cycle 4, and IDLE again in cycle 5.
REQ-032 if_rdata and ls_rdata SHALL hold their last delivered value until that requester's next response.
REQ-033 Requests SHALL be sampled only in IDLE; a request held through a transaction SHALL be treated as a new request on return to IDLE.
REQ-034 gnt, rvalid and mem_en SHALL never be asserted for both requesters in the same cycle.

Reset
REQ-035 On rst high, the FSM SHALL go to IDLE immediately and every output SHALL read 0, including rdata and fsm_state.
REQ-036 On reset, the last-grant pointer SHALL be set to IF, so ls wins the first tie.
REQ-037 Reset mid-transaction SHALL abandon the transaction, with no later gnt or rvalid for it.

Structure
REQ-038 A shared package SHALL hold the state encoding, the requester IDs (IF=0, LS=1) and MEM_LAT_DEFAULT=2.
REQ-039 The 2-way round-robin pick SHALL be a sub-module rr_arb2 (inputs req[1:0] and last, output win), purely combinational.

Verification
REQ-040 Bench SHALL cover: if_req only, addr 0x0010, memory returns 0xBEEF -> if_gnt in cycle 1, if_rvalid in cycle 4 with if_rdata=0xBEEF.
REQ-041 Bench SHALL cover: ls store, addr 0x0200, wdata 0x1234 -> mem_en=mem_we=1 with those values for one cycle, ls_gnt pulse, no ls_rvalid, busy low 2 cycles after the request.
REQ-042 Bench SHALL cover: if_req and ls_req both held high after reset -> grant order LS, IF, LS, IF.
REQ-043 Bench SHALL cover: rst pulsed during WAIT of a load -> all outputs 0 immediately, no ls_rvalid afterwards, next tie granted to LS.
REQ-044 Bench SHALL cover: MEM_LAT=1 and MEM_LAT=7 reads -> rvalid exactly MEM_LAT+2 cycles after the request-sample cycle.
REQ-045 Bench SHALL check an assertion that busy equals (fsm_state != 0) in every cycle.
